pipe_controller: RTL and testbench

- Second-generation control unit for the 3-stage RV32 pipeline (IF / EX / WB).
- Decodes the EX-stage instruction combinationally into EX-stage controls.
- Registers the memory and write-back controls into a WB-stage control register.
- Squashes the wrong-path instruction after a taken branch or jump, counts illegal instructions, and, as an option, stalls the pipeline for multi-cycle M-extension ops.

---
 rtl/pipe_controller.sv | 323 ++++++++++++++++++++++++++++++++
 tb/tb_pipe_controller.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_controller.sv
// pipe_controller: EX-stage decode, WB control register, wrong-path squash and illegal counting.
// Optional multi-cycle M-extension stall is enabled by defining PIPE_CTRL_M_EXT_EN.
module pipe_controller #(
    parameter int unsigned MUL_LAT   = 2,
    parameter int unsigned DIV_LAT   = 8,
    parameter int unsigned ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 instr_valid,
    input  logic [6:0]           opcode,
    input  logic [2:0]           func3,
    input  logic [6:0]           func7,
    input  logic                 br_taken,
    output logic                 sel_opr_a,
    output logic                 sel_opr_b,
    output logic [4:0]           aluop,
    output logic [2:0]           imm_type,
    output logic [2:0]           br_type,
    output logic                 sel_pc,
    output logic                 stall,
    output logic                 flush,
    output logic                 rf_en_wb,
    output logic                 rd_en_wb,
    output logic                 wr_en_wb,
    output logic [1:0]           sel_wb_wb,
    output logic [2:0]           mem_type_wb,
    output logic                 illegal,
    output logic [ILL_CNT_W-1:0] ill_cnt
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_SUB   = 5'd1;
    localparam logic [4:0] ALU_SLL   = 5'd2;
    localparam logic [4:0] ALU_SLT   = 5'd3;
    localparam logic [4:0] ALU_SLTU  = 5'd4;
    localparam logic [4:0] ALU_XOR   = 5'd5;
    localparam logic [4:0] ALU_SRL   = 5'd6;
    localparam logic [4:0] ALU_SRA   = 5'd7;
    localparam logic [4:0] ALU_OR    = 5'd8;
    localparam logic [4:0] ALU_AND   = 5'd9;
    localparam logic [4:0] ALU_PASSB = 5'd10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_J = 3'b001;
    localparam logic [2:0] IMM_U = 3'b010;
    localparam logic [2:0] IMM_B = 3'b011;
    localparam logic [2:0] IMM_S = 3'b100;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_MEM  = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;
    localparam logic [1:0] WB_NONE = 2'b11;

    typedef struct packed {
        logic       sel_a;
        logic       sel_b;
        logic [4:0] alu;
        logic [2:0] imm;
        logic [2:0] br;
        logic       jump;
        logic       branch;
        logic       rf;
        logic       rd;
        logic       wr;
        logic [1:0] wb;
        logic [2:0] mem;
    } ex_ctrl_t;

    typedef struct packed {
        logic       rf;
        logic       rd;
        logic       wr;
        logic [1:0] wb;
        logic [2:0] mem;
    } wb_ctrl_t;

    localparam ex_ctrl_t EX_BUBBLE = '{sel_a: 1'b0, sel_b: 1'b0, alu: ALU_ADD, imm: IMM_I,
                                       br: 3'b000, jump: 1'b0, branch: 1'b0, rf: 1'b0,
                                       rd: 1'b0, wr: 1'b0, wb: WB_NONE, mem: 3'b000};
    localparam wb_ctrl_t WB_BUBBLE = '{rf: 1'b0, rd: 1'b0, wr: 1'b0, wb: WB_NONE, mem: 3'b000};

    ex_ctrl_t             ex_c;
    wb_ctrl_t             wb_q, wb_d;
    logic                 ill_c;
    logic                 kill_q;
    logic                 illegal_q;
    logic [ILL_CNT_W-1:0] ill_cnt_q, ill_cnt_d;
`ifdef PIPE_CTRL_M_EXT_EN
    logic                 m_op_c;
    logic                 div_op_c;
`endif

    // Effective EX decode: bubble when invalid, squashed or illegal.
    always_comb begin
        ex_c  = EX_BUBBLE;
        ill_c = 1'b0;
`ifdef PIPE_CTRL_M_EXT_EN
        m_op_c   = 1'b0;
        div_op_c = 1'b0;
`endif
        if (instr_valid && !kill_q) begin
            case (opcode)
                OP_R: begin
                    ex_c.rf = 1'b1;
                    ex_c.wb = WB_ALU;
                    case (func7)
                        F7_BASE: begin
                            case (func3)
                                3'b000:  ex_c.alu = ALU_ADD;
                                3'b001:  ex_c.alu = ALU_SLL;
                                3'b010:  ex_c.alu = ALU_SLT;
                                3'b011:  ex_c.alu = ALU_SLTU;
                                3'b100:  ex_c.alu = ALU_XOR;
                                3'b101:  ex_c.alu = ALU_SRL;
                                3'b110:  ex_c.alu = ALU_OR;
                                default: ex_c.alu = ALU_AND;
                            endcase
                        end
                        F7_ALT: begin
                            if (func3 == 3'b000)      ex_c.alu = ALU_SUB;
                            else if (func3 == 3'b101) ex_c.alu = ALU_SRA;
                            else                      ill_c = 1'b1;
                        end
`ifdef PIPE_CTRL_M_EXT_EN
                        7'b0000001: begin
                            // MUL..REMU occupy consecutive aluop codes starting at 11
                            m_op_c   = 1'b1;
                            div_op_c = func3[2];
                            ex_c.alu = 5'd11 + 5'(func3);
                        end
`endif
                        default: ill_c = 1'b1;
                    endcase
                end
                OP_IMM: begin
                    ex_c.sel_b = 1'b1;
                    ex_c.rf    = 1'b1;
                    ex_c.wb    = WB_ALU;
                    case (func3)
                        3'b000: ex_c.alu = ALU_ADD;
                        3'b001: begin
                            if (func7 == F7_BASE) ex_c.alu = ALU_SLL;
                            else                  ill_c = 1'b1;
                        end
                        3'b010: ex_c.alu = ALU_SLT;
                        3'b011: ex_c.alu = ALU_SLTU;
                        3'b100: ex_c.alu = ALU_XOR;
                        3'b101: begin
                            if (func7 == F7_BASE)     ex_c.alu = ALU_SRL;
                            else if (func7 == F7_ALT) ex_c.alu = ALU_SRA;
                            else                      ill_c = 1'b1;
                        end
                        3'b110:  ex_c.alu = ALU_OR;
                        default: ex_c.alu = ALU_AND;
                    endcase
                end
                OP_JALR: begin
                    ex_c.sel_b = 1'b1;
                    ex_c.jump  = 1'b1;
                    ex_c.rf    = 1'b1;
                    ex_c.wb    = WB_PC4;
                end
                OP_JAL: begin
                    ex_c.sel_a = 1'b1;
                    ex_c.sel_b = 1'b1;
                    ex_c.imm   = IMM_J;
                    ex_c.jump  = 1'b1;
                    ex_c.rf    = 1'b1;
                    ex_c.wb    = WB_PC4;
                end
                OP_LUI: begin
                    ex_c.sel_b = 1'b1;
                    ex_c.alu   = ALU_PASSB;
                    ex_c.imm   = IMM_U;
                    ex_c.rf    = 1'b1;
                    ex_c.wb    = WB_ALU;
                end
                OP_AUIPC: begin
                    ex_c.sel_a = 1'b1;
                    ex_c.sel_b = 1'b1;
                    ex_c.imm   = IMM_U;
                    ex_c.rf    = 1'b1;
                    ex_c.wb    = WB_ALU;
                end
                OP_BRANCH: begin
                    ex_c.sel_a  = 1'b1;
                    ex_c.sel_b  = 1'b1;
                    ex_c.imm    = IMM_B;
                    ex_c.branch = 1'b1;
                    case (func3)
                        3'b000:  ex_c.br = 3'b000;
                        3'b001:  ex_c.br = 3'b001;
                        3'b100:  ex_c.br = 3'b010;
                        3'b101:  ex_c.br = 3'b011;
                        3'b110:  ex_c.br = 3'b100;
                        3'b111:  ex_c.br = 3'b101;
                        default: ill_c = 1'b1;
                    endcase
                end
                OP_LOAD: begin
                    ex_c.sel_b = 1'b1;
                    ex_c.rd    = 1'b1;
                    ex_c.rf    = 1'b1;
                    ex_c.wb    = WB_MEM;
                    case (func3)
                        3'b000:  ex_c.mem = 3'b000;
                        3'b001:  ex_c.mem = 3'b001;
                        3'b010:  ex_c.mem = 3'b010;
                        3'b100:  ex_c.mem = 3'b011;
                        3'b101:  ex_c.mem = 3'b100;
                        default: ill_c = 1'b1;
                    endcase
                end
                OP_STORE: begin
                    ex_c.sel_b = 1'b1;
                    ex_c.imm   = IMM_S;
                    ex_c.wr    = 1'b1;
                    case (func3)
                        3'b000:  ex_c.mem = 3'b000;
                        3'b001:  ex_c.mem = 3'b001;
                        3'b010:  ex_c.mem = 3'b010;
                        default: ill_c = 1'b1;
                    endcase
                end
                default: ill_c = 1'b1;
            endcase
            if (ill_c) begin
                ex_c = EX_BUBBLE;
`ifdef PIPE_CTRL_M_EXT_EN
                m_op_c   = 1'b0;
                div_op_c = 1'b0;
`endif
            end
        end
    end

    assign sel_opr_a = ex_c.sel_a;
    assign sel_opr_b = ex_c.sel_b;
    assign aluop     = ex_c.alu;
    assign imm_type  = ex_c.imm;
    assign br_type   = ex_c.br;
    assign sel_pc    = ex_c.jump | (ex_c.branch & br_taken);
    assign flush     = sel_pc;

`ifdef PIPE_CTRL_M_EXT_EN
    localparam int unsigned LAT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = $clog2(LAT_MAX + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] lat_m1_c;
    logic             m_first_c;

    // Remaining EX cycles of a multi-cycle op; WB captures it when the count hits zero.
    always_comb begin
        lat_m1_c  = div_op_c ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
        m_first_c = m_op_c && (cnt_q == '0) && (lat_m1_c != '0);
        cnt_d     = cnt_q;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else if (m_first_c) begin
            cnt_d = lat_m1_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign stall = rst_n & (m_first_c | (cnt_q > CNT_W'(1)));
`else
    logic unused_lat;
    assign unused_lat = ^{MUL_LAT, DIV_LAT};
    assign stall      = 1'b0;
`endif

    always_comb begin
        wb_d = WB_BUBBLE;
        if (!stall) begin
            wb_d = '{rf: ex_c.rf, rd: ex_c.rd, wr: ex_c.wr, wb: ex_c.wb, mem: ex_c.mem};
        end
        ill_cnt_d = ill_cnt_q;
        if (ill_c && !(&ill_cnt_q)) begin
            ill_cnt_d = ill_cnt_q + ILL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_q      <= WB_BUBBLE;
            kill_q    <= 1'b0;
            illegal_q <= 1'b0;
            ill_cnt_q <= '0;
        end else begin
            wb_q      <= wb_d;
            kill_q    <= sel_pc;
            illegal_q <= ill_c;
            ill_cnt_q <= ill_cnt_d;
        end
    end

    assign rf_en_wb    = wb_q.rf;
    assign rd_en_wb    = wb_q.rd;
    assign wr_en_wb    = wb_q.wr;
    assign sel_wb_wb   = wb_q.wb;
    assign mem_type_wb = wb_q.mem;
    assign illegal     = illegal_q;
    assign ill_cnt     = ill_cnt_q;

endmodule

// File: tb/tb_pipe_controller.sv
// Scoreboard bench for pipe_controller; expected WB controls are queued at drive time.
module tb_pipe_controller;

`ifdef PIPE_CTRL_M_EXT_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    localparam logic [6:0] R   = 7'b0110011;
    localparam logic [6:0] IMM = 7'b0010011;
    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] BAD = 7'b1111111;

    typedef struct packed {
        logic       rf;
        logic       rd;
        logic       wr;
        logic [1:0] wb;
        logic [2:0] mem;
        logic       ill;
    } wbx_t;

    localparam wbx_t BUB = 9'b000_11_000_0;
    localparam wbx_t ILL = 9'b000_11_000_1;
    localparam wbx_t ALU = 9'b100_00_000_0;

    logic       clk, rst_n, instr_valid, br_taken;
    logic [6:0] opcode, func7;
    logic [2:0] func3;
    logic       sel_opr_a, sel_opr_b, sel_pc, stall, flush;
    logic [4:0] aluop;
    logic [2:0] imm_type, br_type, mem_type_wb;
    logic       rf_en_wb, rd_en_wb, wr_en_wb, illegal;
    logic [1:0] sel_wb_wb;
    logic [7:0] ill_cnt;

    int         n_vec = 0;
    int         n_err = 0;
    wbx_t       sb[$];
    logic [7:0] exp_cnt;

    pipe_controller #(.MUL_LAT(2), .DIV_LAT(8), .ILL_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .opcode(opcode),
        .func3(func3), .func7(func7), .br_taken(br_taken),
        .sel_opr_a(sel_opr_a), .sel_opr_b(sel_opr_b), .aluop(aluop),
        .imm_type(imm_type), .br_type(br_type), .sel_pc(sel_pc), .stall(stall),
        .flush(flush), .rf_en_wb(rf_en_wb), .rd_en_wb(rd_en_wb), .wr_en_wb(wr_en_wb),
        .sel_wb_wb(sel_wb_wb), .mem_type_wb(mem_type_wb), .illegal(illegal),
        .ill_cnt(ill_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic wbx_t mk(input logic rf, input logic rd, input logic wr,
                                input logic [1:0] wb, input logic [2:0] mem);
        return {rf, rd, wr, wb, mem, 1'b0};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wb_now();
        return 32'({rf_en_wb, rd_en_wb, wr_en_wb, sel_wb_wb, mem_type_wb, illegal});
    endfunction

    task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic bt, input wbx_t e);
        instr_valid = v;
        opcode      = op;
        func3       = f3;
        func7       = f7;
        br_taken    = bt;
        sb.push_back(e);
        #1;
    endtask

    task automatic tick();
        wbx_t e;
        @(posedge clk);
        #1;
        check("sb_level", 32'(sb.size()), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.ill && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
            check("wb", wb_now(), 32'(e));
            check("ill_cnt", 32'(ill_cnt), 32'(exp_cnt));
        end
    endtask

    function automatic wbx_t div_exp(input int k, input int lat);
        if (!M_EN)         return ILL;
        else if (k < lat - 1) return BUB;
        else               return ALU;
    endfunction

    initial begin
        rst_n = 1'b0; instr_valid = 1'b0; opcode = '0; func3 = '0; func7 = '0;
        br_taken = 1'b0; exp_cnt = '0;
        #12;
        check("rst_wb", wb_now(), 32'(BUB));
        check("rst_cnt", 32'(ill_cnt), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        drive(1'b1, R, 3'b000, 7'b0000000, 1'b0, ALU);
        check("add_alu", 32'(aluop), 32'd0);
        check("add_selb", 32'(sel_opr_b), 32'd0);
        tick();
        drive(1'b1, LD, 3'b010, 7'b0, 1'b0, mk(1, 1, 0, 2'b01, 3'b010));
        check("lw_selb", 32'(sel_opr_b), 32'd1);
        check("lw_imm", 32'(imm_type), 32'd0);
        tick();
        drive(1'b1, LD, 3'b101, 7'b0, 1'b0, mk(1, 1, 0, 2'b01, 3'b100));
        tick();
        drive(1'b1, R, 3'b000, 7'b0100000, 1'b0, ALU);
        check("sub_alu", 32'(aluop), 32'd1);
        tick();
        drive(1'b1, IMM, 3'b101, 7'b0100000, 1'b0, ALU);
        check("srai_alu", 32'(aluop), 32'd7);
        tick();
        drive(1'b1, 7'b0110111, 3'b000, 7'b0, 1'b0, ALU);
        check("lui_alu", 32'(aluop), 32'd10);
        check("lui_imm", 32'(imm_type), 32'b010);
        tick();

        // Taken BNE squashes the following SW; the one after decodes normally.
        drive(1'b1, BR, 3'b001, 7'b0, 1'b1, BUB);
        check("bne_selpc", 32'(sel_pc), 32'd1);
        check("bne_flush", 32'(flush), 32'd1);
        check("bne_brtype", 32'(br_type), 32'b001);
        check("bne_imm", 32'(imm_type), 32'b011);
        tick();
        drive(1'b1, ST, 3'b010, 7'b0, 1'b0, BUB);
        check("sq_selb", 32'(sel_opr_b), 32'd0);
        check("sq_selpc", 32'(sel_pc), 32'd0);
        tick();
        drive(1'b1, ST, 3'b010, 7'b0, 1'b0, mk(0, 0, 1, 2'b11, 3'b010));
        check("sw_imm", 32'(imm_type), 32'b100);
        tick();
        drive(1'b1, BR, 3'b000, 7'b0, 1'b0, BUB);
        check("beq_nt_selpc", 32'(sel_pc), 32'd0);
        tick();
        drive(1'b1, IMM, 3'b000, 7'b0, 1'b0, ALU);
        tick();
        drive(1'b1, 7'b1101111, 3'b000, 7'b0, 1'b0, mk(1, 0, 0, 2'b10, 3'b000));
        check("jal_selpc", 32'(sel_pc), 32'd1);
        check("jal_sela", 32'(sel_opr_a), 32'd1);
        check("jal_imm", 32'(imm_type), 32'b001);
        tick();
        drive(1'b1, BAD, 3'b000, 7'b0, 1'b0, BUB);
        tick();

        drive(1'b1, BAD, 3'b000, 7'b0, 1'b0, ILL);
        tick();
        drive(1'b1, BR, 3'b010, 7'b0, 1'b0, ILL);
        tick();
        check("ill_two", 32'(ill_cnt), 32'd2);
        drive(1'b0, BAD, 3'b000, 7'b0, 1'b0, BUB);
        tick();
        drive(1'b1, R, 3'b001, 7'b0100000, 1'b0, ILL);
        tick();
        drive(1'b1, ST, 3'b011, 7'b0, 1'b0, ILL);
        tick();
        drive(1'b1, LD, 3'b110, 7'b0, 1'b0, ILL);
        tick();
        drive(1'b1, IMM, 3'b001, 7'b0100000, 1'b0, ILL);
        tick();

        // DIV held in EX for its full latency.
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, R, 3'b100, 7'b0000001, 1'b0, div_exp(k, 8));
            check("div_alu", 32'(aluop), M_EN ? 32'd15 : 32'd0);
            check("div_stall", 32'(stall), 32'(M_EN && k < 7));
            tick();
        end
        drive(1'b1, R, 3'b000, 7'b0, 1'b0, ALU);
        check("post_div_stall", 32'(stall), 32'd0);
        tick();
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 2; k++) begin
                drive(1'b1, R, 3'b000, 7'b0000001, 1'b0, div_exp(k, 2));
                check("mul_alu", 32'(aluop), M_EN ? 32'd11 : 32'd0);
                check("mul_stall", 32'(stall), 32'(M_EN && k == 0));
                tick();
            end
        end

        for (int i = 0; i < 256; i++) begin
            drive(1'b1, BAD, 3'b000, 7'b0, 1'b0, ILL);
            tick();
        end
        check("ill_sat", 32'(ill_cnt), 32'd255);

        // Reset asserted in the third cycle of a DIV.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, R, 3'b100, 7'b0000001, 1'b0, div_exp(k, 8));
            if (k < 2) tick();
        end
        check("pre_rst_stall", 32'(stall), 32'(M_EN));
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_stall", 32'(stall), 32'd0);
        check("rst_mid_wb", wb_now(), 32'(BUB));
        check("rst_mid_cnt", 32'(ill_cnt), 32'd0);
        sb.delete();
        exp_cnt = '0;
        @(posedge clk);
        #1;
        check("rst_hold_wb", wb_now(), 32'(BUB));
        rst_n = 1'b1;
        drive(1'b1, R, 3'b000, 7'b0, 1'b0, ALU);
        check("rel_add_stall", 32'(stall), 32'd0);
        tick();
        drive(1'b0, R, 3'b000, 7'b0, 1'b0, BUB);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
